// File: rtl/uart_pkg.sv
// Shared UART definitions: line-control field encodings used by the TX and RX paths.
package uart_pkg;

    typedef enum logic [1:0] {
        WL5 = 2'd0,
        WL6 = 2'd1,
        WL7 = 2'd2,
        WL8 = 2'd3
    } word_len_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one character per valid/ready handshake, serialised LSB-first
// with start bit, 5-8 data bits, optional parity and 1/1.5/2 stop bits at 16x oversampling.
module uart_tx
    import uart_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      div_clk_en,
    input  logic      tx_valid,
    output logic      tx_ready,
    input  logic [7:0] tx_data,
    output logic      tx,
    output logic      tx_busy,
    input  word_len_e cfg_word_len,
    input  logic      cfg_parity_en,
    input  logic      cfg_even_parity,
    input  logic      cfg_force_parity,
    input  logic      cfg_stop_bits,
    input  logic      cfg_break
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e    state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic       stop_2nd_q, stop_2nd_d;
    logic       tx_q, tx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q;
    logic       pen_q;
    logic       stop2_q;
    word_len_e  wl_q;
    logic       accept;
    logic       bit_end;
    logic       line_bit;

    function automatic logic [7:0] data_mask(input word_len_e wl);
        case (wl)
            WL5:     data_mask = 8'h1F;
            WL6:     data_mask = 8'h3F;
            WL7:     data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    endfunction

    // Stick parity ignores the data: the bit is the inverse of the even/odd select.
    function automatic logic parity_bit(input logic [7:0] d, input word_len_e wl,
                                        input logic even, input logic stick);
        logic x;
        x = ^(d & data_mask(wl));
        if (stick)
            parity_bit = ~even;
        else
            parity_bit = even ? x : ~x;
    endfunction

    assign accept  = tx_valid & (state_q == S_IDLE);
    assign bit_end = div_clk_en & (cnt_q == 4'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        stop_2nd_d = stop_2nd_q;
        line_bit   = 1'b1;

        if (div_clk_en && (state_q != S_IDLE) && (cnt_q != 4'd0))
            cnt_d = cnt_q - 4'd1;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d    = S_START;
                    cnt_d      = 4'd15;
                    shift_d    = tx_data;
                    stop_2nd_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = 4'd15;
                    // word length minus one is 4..7, i.e. the encoding with bit 2 set
                    idx_d   = {1'b1, wl_q};
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = 4'd15;
                    if (idx_q == 3'd0)
                        state_d = pen_q ? S_PARITY : S_STOP;
                    else
                        idx_d = idx_q - 3'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = 4'd15;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_2nd_q) begin
                        // second stop period is a half bit for 5-bit words
                        stop_2nd_d = 1'b1;
                        cnt_d      = (wl_q == WL5) ? 4'd7 : 4'd15;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START:  line_bit = 1'b0;
            S_DATA:   line_bit = shift_d[0];
            S_PARITY: line_bit = par_q;
            default:  line_bit = 1'b1;
        endcase

        tx_d = line_bit & ~cfg_break;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= 3'd0;
            stop_2nd_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_2nd_q <= stop_2nd_d;
            tx_q       <= tx_d;
        end
    end

    // Frame data and line configuration are captured once per accept.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (accept) begin
            par_q   <= parity_bit(tx_data, cfg_word_len, cfg_even_parity, cfg_force_parity);
            pen_q   <= cfg_parity_en;
            stop2_q <= cfg_stop_bits;
            wl_q    <= cfg_word_len;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frame formats plus hand sequences for
// back-to-back, break, clock-enable freeze and mid-frame reset.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       div_clk_en;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    word_len_e  cfg_word_len;
    logic       cfg_parity_en;
    logic       cfg_even_parity;
    logic       cfg_force_parity;
    logic       cfg_stop_bits;
    logic       cfg_break;

    logic       div_run;
    logic [1:0] divcnt;

    int total = 0;
    int bad   = 0;
    int pcount;
    int cap_cyc;
    logic [11:0] cap_bits;

    typedef struct {
        logic [7:0]  data;
        word_len_e   wl;
        logic        pen;
        logic        even;
        logic        stick;
        logic        stop2;
        int          nbits;
        logic [11:0] bits;
        int          pulses;
    } vec_t;

    vec_t vecs[9];

    uart_tx dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .div_clk_en       (div_clk_en),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .tx_data          (tx_data),
        .tx               (tx),
        .tx_busy          (tx_busy),
        .cfg_word_len     (cfg_word_len),
        .cfg_parity_en    (cfg_parity_en),
        .cfg_even_parity  (cfg_even_parity),
        .cfg_force_parity (cfg_force_parity),
        .cfg_stop_bits    (cfg_stop_bits),
        .cfg_break        (cfg_break)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!div_run) divcnt <= 2'd0;
        else          divcnt <= divcnt + 2'd1;
    end
    assign div_clk_en = div_run && (divcnt == 2'd3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one clock, sampling at the negedge; returns whether a pulse edge passed
    task automatic step(output logic p);
        p = div_clk_en;
        @(negedge clk);
        if (p) pcount++;
    endtask

    task automatic start_aligned(input vec_t v);
        int guard = 0;
        while (!div_clk_en && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        tx_data          = v.data;
        cfg_word_len     = v.wl;
        cfg_parity_en    = v.pen;
        cfg_even_parity  = v.even;
        cfg_force_parity = v.stick;
        cfg_stop_bits    = v.stop2;
        tx_valid         = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        pcount   = 0;
    endtask

    task automatic capture(input int nbits);
        logic p;
        int   guard = 0;
        cap_bits = '0;
        cap_cyc  = 0;
        while (tx_busy && guard < 6000) begin
            cap_cyc++;
            step(p);
            if (p && (pcount % 16 == 8) && (pcount / 16 < nbits))
                cap_bits[pcount / 16] = tx;
            guard++;
        end
        if (guard >= 6000) begin
            total++;
            bad++;
            $display("FAIL capture_timeout: busy still %0b after %0d cycles", tx_busy, guard);
        end
    endtask

    task automatic run_pulses(input int target);
        logic p;
        int   guard = 0;
        while (pcount < target && guard < 6000) begin
            step(p);
            guard++;
        end
        if (guard >= 6000) begin
            total++;
            bad++;
            $display("FAIL pulse_timeout: reached %0d of %0d pulses", pcount, target);
        end
    endtask

    initial begin
        logic [7:0]  b2b_data[3];
        logic [11:0] b2b_bits[3];
        logic        p;
        logic        held;
        vec_t        v;

        vecs[0] = '{8'h55, WL8, 1'b0, 1'b0, 1'b0, 1'b0, 10, 12'h2AA, 160};
        vecs[1] = '{8'hFF, WL7, 1'b1, 1'b1, 1'b0, 1'b0, 10, 12'h3FE, 160};
        vecs[2] = '{8'hFF, WL7, 1'b1, 1'b0, 1'b0, 1'b0, 10, 12'h2FE, 160};
        vecs[3] = '{8'h13, WL5, 1'b0, 1'b0, 1'b0, 1'b1,  7, 12'h066, 120};
        vecs[4] = '{8'h2A, WL6, 1'b0, 1'b0, 1'b0, 1'b1,  8, 12'h0D4, 144};
        vecs[5] = '{8'h00, WL8, 1'b1, 1'b0, 1'b1, 1'b0, 11, 12'h600, 176};
        vecs[6] = '{8'h00, WL8, 1'b1, 1'b1, 1'b1, 1'b0, 11, 12'h400, 176};
        vecs[7] = '{8'hA5, WL8, 1'b1, 1'b1, 1'b0, 1'b1, 11, 12'h54A, 192};
        vecs[8] = '{8'hE3, WL5, 1'b1, 1'b0, 1'b0, 1'b0,  8, 12'h0C6, 128};

        rst_n = 1'b0; div_run = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        cfg_word_len = WL8; cfg_parity_en = 1'b0; cfg_even_parity = 1'b0;
        cfg_force_parity = 1'b0; cfg_stop_bits = 1'b0; cfg_break = 1'b0;
        pcount = 0;
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_busy", {31'd0, tx_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            start_aligned(v);
            chk($sformatf("v%0d_start_tx", i), {31'd0, tx}, 32'd0);
            // scramble inputs mid-frame; the latched copy must be used
            tx_data          = ~v.data;
            cfg_word_len     = word_len_e'(~v.wl);
            cfg_parity_en    = ~v.pen;
            cfg_even_parity  = ~v.even;
            cfg_force_parity = ~v.stick;
            cfg_stop_bits    = ~v.stop2;
            capture(v.nbits);
            chk($sformatf("v%0d_bits", i), {20'd0, cap_bits}, {20'd0, v.bits});
            chk($sformatf("v%0d_pulses", i), pcount, v.pulses);
            chk($sformatf("v%0d_clks", i), cap_cyc, v.pulses * 4);
            chk($sformatf("v%0d_ready_after", i), {30'd0, tx_ready, tx}, 32'd3);
            repeat (2) @(negedge clk);
        end

        // back-to-back with tx_valid held
        b2b_data[0] = 8'h0F; b2b_data[1] = 8'h81; b2b_data[2] = 8'h3C;
        b2b_bits[0] = 12'h21E; b2b_bits[1] = 12'h302; b2b_bits[2] = 12'h278;
        v = vecs[0];
        v.data = b2b_data[0];
        start_aligned(v);
        tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) tx_data = b2b_data[k + 1];
            else       tx_valid = 1'b0;
            pcount = 0;
            capture(10);
            chk($sformatf("b2b%0d_bits", k), {20'd0, cap_bits}, {20'd0, b2b_bits[k]});
            chk($sformatf("b2b%0d_gap_ready", k), {30'd0, tx_ready, tx}, 32'd3);
            if (k < 2) begin
                @(negedge clk);
                chk($sformatf("b2b%0d_restart", k), {30'd0, tx_busy, tx}, 32'd2);
            end
        end
        repeat (3) @(negedge clk);

        // break asserted mid-DATA, released during STOP
        v = vecs[0];
        v.data = 8'hFF;
        start_aligned(v);
        run_pulses(40);
        chk("brk_pre", {31'd0, tx}, 32'd1);
        cfg_break = 1'b1;
        step(p);
        chk("brk_low", {31'd0, tx}, 32'd0);
        run_pulses(150);
        chk("brk_in_stop", {30'd0, tx_busy, tx}, 32'd2);
        cfg_break = 1'b0;
        step(p);
        chk("brk_release", {31'd0, tx}, 32'd1);
        capture(0);
        chk("brk_total_pulses", pcount, 160);
        chk("brk_idle", {30'd0, tx_ready, tx_busy}, 32'd2);
        repeat (2) @(negedge clk);

        // clock enable held low freezes the frame
        v = vecs[0];
        start_aligned(v);
        run_pulses(20);
        div_run = 1'b0;
        held = tx;
        repeat (40) step(p);
        chk("freeze_tx", {31'd0, tx}, {31'd0, held});
        chk("freeze_busy_pulses", {tx_busy, 31'(pcount)}, {1'b1, 31'd20});
        div_run = 1'b1;
        capture(0);
        chk("freeze_total_pulses", pcount, 160);
        repeat (2) @(negedge clk);

        // asynchronous reset mid-frame
        v = vecs[0];
        v.data = 8'h00;
        start_aligned(v);
        run_pulses(50);
        chk("rst_pre_tx", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_async", {29'd0, tx, tx_ready, tx_busy}, 32'd6);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) step(p);
        chk("rst_dropped", {29'd0, tx, tx_ready, tx_busy}, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter half of the UART; the counterpart of the receive path.
- Accepts one character per valid/ready handshake and serialises it LSB-first: start bit, 5-8 data bits, optional parity, 1/1.5/2 stop bits.
- Bit timing comes from the shared divided-clock enable (16 x baud).
- Sits between the TX holding register / FIFO and the tx pin, under the same line-control configuration as the receiver.

Parameters:
- none. Widths are fixed by uart_pkg.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- div_clk_en  input  1  one-cycle enable pulse at 16 x baud rate
- tx_valid  input  1  character available
- tx_ready  output  1  transmitter can accept a character
- tx_data  input  8  character; only the low cfg_word_len bits are sent
- tx  output  1  serial output, idle high
- tx_busy  output  1  frame in progress (used for transmitter-empty status)
- cfg_word_len  input  uart_pkg::word_len_e  5/6/7/8 data bits
- cfg_parity_en  input  1  parity bit enabled
- cfg_even_parity  input  1  1 = even parity, 0 = odd parity
- cfg_force_parity  input  1  stick parity
- cfg_stop_bits  input  1  0 = one stop bit; 1 = two stop bits (1.5 when word length is 5)
- cfg_break  input  1  force tx low

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state IDLE, tx = 1, tx_ready = 1, tx_busy = 0.
  - Counters cleared; data/config latches are don't-care.
- tx is driven from a flop (glitch-free): tx = line_bit & ~cfg_break.
- Break handling: cfg_break acts combinationally onto the flop input, so tx goes low 1 cycle after cfg_break rises. It is not latched. The FSM keeps running underneath, and the frame completes with normal timing.
- Handshake:
  - tx_ready = (state == IDLE).
  - Accept happens on a posedge with tx_valid & tx_ready.
  - At accept, latch tx_data, cfg_word_len, cfg_parity_en, cfg_even_parity, cfg_force_parity and cfg_stop_bits. Config changes mid-frame have no effect on that frame.
  - tx_data is don't-care when tx_valid = 0.
- Tick counter (4-bit):
  - Loaded with 15 at accept and at every bit boundary.
  - Decrements on div_clk_en.
  - bit_end = div_clk_en & (count == 0).
  - Each bit lasts exactly 16 div_clk_en pulses, except the half stop bit, which is loaded with 7 and lasts 8 pulses.
- FSM states, with tx level per state:
  - IDLE (tx = 1): on accept -> START. tx_busy goes high and tx goes low the cycle after accept.
  - START (tx = 0): on bit_end -> DATA. Data index is loaded with word length - 1.
  - DATA (tx = shift[0]): on bit_end, shift right. When the index reaches 0, go to PARITY if parity is enabled, else STOP.
  - PARITY (tx = parity bit): on bit_end -> STOP.
  - STOP (tx = 1):
    - One stop bit: ends after 16 pulses.
    - Two stop bits: 32 pulses.
    - Word length 5 with two stop bits: 24 pulses.
    - On the final bit_end -> IDLE.
  - Illegal encodings -> IDLE.
- Parity bit:
  - Even parity: XOR of the sent data bits.
  - Odd parity: the inverse of that XOR.
  - Stick parity (cfg_force_parity = 1): ~cfg_even_parity, i.e. 1 for odd, 0 for even.
  - Bits above the word length are excluded from the parity.
- tx_busy = (state != IDLE); it deasserts the cycle after the final stop bit_end.
- Back-to-back frames:
  - tx_ready rises 1 cycle after the last stop bit_end.
  - A held tx_valid is accepted in that cycle, so the start bit follows after exactly one clk of idle.
- div_clk_en held low: all counters freeze and tx holds its level.
- Reset mid-frame: return immediately to the reset values; tx = 1. The partial frame is dropped with no completion.

Test Plan:
- 8N1, tx_data = 0x55, div_clk_en every 4 clks -> tx sequence 0,1,0,1,0,1,0,1,0,1. Each bit is 64 clks; tx_busy is high for 640 clks; tx_ready returns afterwards.
- 7E1, tx_data = 0xFF -> 7 ones, parity 1, stop 1; bit 7 not sent. 7O1 with the same data -> parity 0.
- 5 bits, two stop bits, tx_data = 0x13 -> data 1,1,0,0,1, then a stop of exactly 24 div_clk_en pulses. 6 bits, two stop bits -> stop of 32 pulses.
- Stick parity: cfg_force_parity = 1, cfg_even_parity = 0, data 0x00 -> parity 1. cfg_even_parity = 1 -> parity 0.
- tx_valid held high with 3 characters -> frames separated by one idle clk. Changing tx_data or config mid-frame does not alter the current frame.
- Break asserted mid-DATA -> tx = 0 from the next clk. Release during STOP -> tx = 1, the frame ends on schedule, and tx_busy falls. rst_n pulsed mid-frame -> tx = 1, tx_ready = 1 asynchronously.
